// File: rtl/test_monitor_pkg.sv
// rtl/test_monitor_pkg.sv - status encoding and sizing helpers for test_status_monitor
package test_monitor_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } status_e;

  // Slot index width, never narrower than one bit.
  function automatic int idx_width(input int np, input int nf);
    int m;
    m = (np > nf) ? np : nf;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/addr_match_bank.sv
// rtl/addr_match_bank.sv - combinational compare of pc against N packed targets, lowest slot wins
module addr_match_bank #(
  parameter int XLEN  = 32,
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [XLEN-1:0]   pc,
  input  logic [N*XLEN-1:0] targets,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scan from the top slot down so the lowest match is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pc == targets[k*XLEN +: XLEN]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - retired-PC pass/fail/timeout monitor with latched verdict
// Optional hang detection is built when TEST_MONITOR_HANG_DETECT_EN is defined.
module test_status_monitor
  import test_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_PASS    = 2,
  parameter int NUM_FAIL    = 2,
  parameter int HANG_CYCLES = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      pc_valid,
  input  logic [XLEN-1:0]                           pc,
  input  logic [NUM_PASS*XLEN-1:0]                  pass_addr,
  input  logic [NUM_FAIL*XLEN-1:0]                  fail_addr,
  input  logic [XLEN-1:0]                           timeout_limit,
  output logic                                      done,
  output logic [STATUS_W-1:0]                       status,
  output logic [idx_width(NUM_PASS, NUM_FAIL)-1:0]  hit_index,
  output logic [XLEN-1:0]                           cycle_count,
  output logic [XLEN-1:0]                           retire_count,
  output logic [XLEN-1:0]                           final_pc
);

  localparam int IDX_W = idx_width(NUM_PASS, NUM_FAIL);
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  status_e          status_q, status_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic [XLEN-1:0]  cycle_count_q, cycle_count_d;
  logic [XLEN-1:0]  retire_count_q, retire_count_d;
  logic [XLEN-1:0]  final_pc_q, final_pc_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
`ifdef TEST_MONITOR_HANG_DETECT_EN
  logic [XLEN-1:0]  run_len_q, run_len_d;
  logic             hang_now;
`endif

  logic             pass_hit, fail_hit;
  logic [IDX_W-1:0] pass_idx, fail_idx;

  addr_match_bank #(.XLEN(XLEN), .N(NUM_PASS), .IDX_W(IDX_W)) u_pass_bank (
    .pc(pc), .targets(pass_addr), .hit(pass_hit), .idx(pass_idx)
  );

  addr_match_bank #(.XLEN(XLEN), .N(NUM_FAIL), .IDX_W(IDX_W)) u_fail_bank (
    .pc(pc), .targets(fail_addr), .hit(fail_hit), .idx(fail_idx)
  );

  always_comb begin
    status_d       = status_q;
    hit_index_d    = hit_index_q;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    final_pc_d     = final_pc_q;
    last_pc_d      = last_pc_q;
`ifdef TEST_MONITOR_HANG_DETECT_EN
    run_len_d      = run_len_q;
    hang_now       = 1'b0;
`endif
    if (start) begin
      status_d       = ST_RUN;
      hit_index_d    = '0;
      cycle_count_d  = '0;
      retire_count_d = '0;
      final_pc_d     = '0;
      last_pc_d      = '0;
`ifdef TEST_MONITOR_HANG_DETECT_EN
      run_len_d      = '0;
`endif
    end else if (status_q == ST_RUN) begin
      // Counters include the triggering cycle, then freeze with the verdict.
      if (cycle_count_q != ALL_ONES) cycle_count_d = cycle_count_q + ONE;
      if (pc_valid) begin
        if (retire_count_q != ALL_ONES) retire_count_d = retire_count_q + ONE;
        last_pc_d = pc;
      end
`ifdef TEST_MONITOR_HANG_DETECT_EN
      if (pc_valid) begin
        if ((run_len_q != '0) && (pc == last_pc_q)) begin
          if (run_len_q != ALL_ONES) run_len_d = run_len_q + ONE;
        end else begin
          run_len_d = ONE;
        end
        hang_now = (run_len_d == XLEN'(HANG_CYCLES));
      end
`endif
      if (pc_valid && fail_hit) begin
        status_d    = ST_FAIL;
        hit_index_d = fail_idx;
        final_pc_d  = pc;
      end else if (pc_valid && pass_hit) begin
        status_d    = ST_PASS;
        hit_index_d = pass_idx;
        final_pc_d  = pc;
      end else if ((timeout_limit != '0) && ((cycle_count_q + ONE) == timeout_limit)) begin
        status_d   = ST_TIMEOUT;
        final_pc_d = pc_valid ? pc : last_pc_q;
      end
`ifdef TEST_MONITOR_HANG_DETECT_EN
      else if (hang_now) begin
        status_d   = ST_HANG;
        final_pc_d = pc;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q       <= ST_IDLE;
      hit_index_q    <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      final_pc_q     <= '0;
      last_pc_q      <= '0;
`ifdef TEST_MONITOR_HANG_DETECT_EN
      run_len_q      <= '0;
`endif
    end else begin
      status_q       <= status_d;
      hit_index_q    <= hit_index_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      final_pc_q     <= final_pc_d;
      last_pc_q      <= last_pc_d;
`ifdef TEST_MONITOR_HANG_DETECT_EN
      run_len_q      <= run_len_d;
`endif
    end
  end

  assign status       = status_q;
  assign done         = (status_q == ST_PASS) || (status_q == ST_FAIL) ||
                        (status_q == ST_TIMEOUT) || (status_q == ST_HANG);
  assign hit_index    = hit_index_q;
  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;
  assign final_pc     = final_pc_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// tb/tb_test_status_monitor.sv - directed bench with per-cycle reference model for test_status_monitor
module tb_test_status_monitor;

  localparam int HANG_CYCLES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [63:0] pass_addr = '0;
  logic [63:0] fail_addr = '0;
  logic [31:0] timeout_limit = '0;
  logic        done;
  logic [2:0]  status;
  logic        hit_index;
  logic [31:0] cycle_count, retire_count, final_pc;

  test_status_monitor #(.XLEN(32), .NUM_PASS(2), .NUM_FAIL(2), .HANG_CYCLES(HANG_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc),
    .pass_addr(pass_addr), .fail_addr(fail_addr), .timeout_limit(timeout_limit),
    .done(done), .status(status), .hit_index(hit_index), .cycle_count(cycle_count),
    .retire_count(retire_count), .final_pc(final_pc)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Reference model: verdict derived from the history of retired pcs since start.
  int          m_status = 0;
  int          m_hit    = 0;
  logic [31:0] m_cyc    = '0;
  logic [31:0] m_ret    = '0;
  logic [31:0] m_final  = '0;
  logic [31:0] m_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step();
    int fslot, pslot, trail;
    if (rst) begin
      m_status = 0; m_hit = 0; m_cyc = '0; m_ret = '0; m_final = '0; m_hist.delete();
    end else if (start) begin
      m_status = 1; m_hit = 0; m_cyc = '0; m_ret = '0; m_final = '0; m_hist.delete();
    end else if (m_status == 1) begin
      fslot = -1; pslot = -1; trail = 0;
      for (int k = 0; k < 2; k++) begin
        if (pc_valid && fslot < 0 && pc == fail_addr[k*32 +: 32]) fslot = k;
        if (pc_valid && pslot < 0 && pc == pass_addr[k*32 +: 32]) pslot = k;
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (pc_valid) begin
        if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
        m_hist.push_back(pc);
        for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == pc; i--) trail++;
      end
      if (fslot >= 0) begin
        m_status = 3; m_hit = fslot; m_final = pc;
      end else if (pslot >= 0) begin
        m_status = 2; m_hit = pslot; m_final = pc;
      end else if (timeout_limit != 0 && m_cyc == timeout_limit) begin
        m_status = 4; m_final = (m_hist.size() == 0) ? 32'h0 : m_hist[m_hist.size()-1];
      end
`ifdef TEST_MONITOR_HANG_DETECT_EN
      else if (pc_valid && trail == HANG_CYCLES) begin
        m_status = 5; m_final = pc;
      end
`endif
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic [31:0] p);
    rst = r; start = s; pc_valid = v; pc = p;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("status", 32'(status), 32'(m_status));
      chk("done", 32'(done), 32'(m_status >= 2));
      chk("hit_index", 32'(hit_index), 32'(m_hit));
      chk("cycle_count", cycle_count, m_cyc);
      chk("retire_count", retire_count, m_ret);
      chk("final_pc", final_pc, m_final);
    end
  end

  initial begin
    int n;
    pass_addr = {32'h0000_0800, 32'h0000_0100};
    fail_addr = {32'hDEAD_0004, 32'hDEAD_0000};
    timeout_limit = 32'd1000;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("reset_status", 32'(status), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_cycles", cycle_count, 0);

    // PASS after a linear pc stream ending on pass slot 0
    cyc(0, 1, 0, 0);
    for (int i = 0; i <= 64; i++) cyc(0, 0, 1, 32'(i * 4));
    chk("t1_status", 32'(status), 2);
    chk("t1_hit", 32'(hit_index), 0);
    chk("t1_final", final_pc, 32'h100);
    chk("t1_retire", retire_count, 65);
    repeat (3) cyc(0, 0, 1, 32'h4);
    chk("t1_sticky_cycles", cycle_count, 65);

    // restart from PASS, then match pass slot 1
    cyc(0, 1, 0, 0);
    chk("t6_status", 32'(status), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_retire", retire_count, 0);
    cyc(0, 0, 1, 32'h300);
    cyc(0, 0, 1, 32'h800);
    chk("t6_pass_slot1", 32'(hit_index), 1);

    // FAIL beats PASS on a shared address; pc ignored without pc_valid
    pass_addr = {32'h0000_0200, 32'h0000_0100};
    fail_addr = {32'hDEAD_0004, 32'h0000_0200};
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 32'h200);
    chk("t2_no_valid", 32'(status), 1);
    cyc(0, 0, 1, 32'h200);
    chk("t2_status", 32'(status), 3);
    chk("t2_hit", 32'(hit_index), 0);

    // TIMEOUT after exactly 10 RUN cycles, final_pc = last valid pc
    timeout_limit = 32'd10;
    cyc(0, 1, 0, 0);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, (k == 3), 32'h44);
      if (done) begin n = k; break; end
    end
    chk("t3_latency", 32'(n), 10);
    chk("t3_status", 32'(status), 4);
    chk("t3_cycles", cycle_count, 10);
    chk("t3_final", final_pc, 32'h44);

    // PASS beats TIMEOUT on the timeout cycle itself
    timeout_limit = 32'd3;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100);
    chk("prio_pass_over_timeout", 32'(status), 2);

    // rst mid-RUN, IDLE holds counters, restart counts from 0
    timeout_limit = 32'd0;
    cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 1, 32'h10);
    cyc(1, 0, 1, 32'h10);
    chk("t4_status", 32'(status), 0);
    chk("t4_cycles", cycle_count, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("t4_idle_cycles", cycle_count, 0);
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    chk("t4_restart_cycles", cycle_count, 4);
    cyc(1, 1, 0, 0);
    chk("rst_beats_start", 32'(status), 0);

    // repeated non-target pc: HANG only in the hang-detect build
    pass_addr = {32'h0000_0800, 32'h0000_0100};
    cyc(0, 1, 0, 0);
    repeat (HANG_CYCLES) cyc(0, 0, 1, 32'h40);
`ifdef TEST_MONITOR_HANG_DETECT_EN
    chk("t5_status", 32'(status), 5);
    chk("t5_final", final_pc, 32'h40);
`else
    chk("t5_status", 32'(status), 1);
    chk("t5_final", final_pc, 32'h0);
`endif
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h100);
    chk("t5_pass_self_loop", 32'(status), 2);
    repeat (HANG_CYCLES) cyc(0, 0, 1, 32'h100);
    chk("t5_pass_sticky", 32'(status), 2);

    cyc(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
